// File: rtl/wishbone_classic_burst_master_if.sv
// Wishbone classic bus bundle with cti/bte burst tags, shared by the burst master and its slave.
interface wishbone_classic_burst_master_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 4
) ();
  logic                     m_wb_cyc;
  logic                     m_wb_stb;
  logic                     m_wb_we;
  logic [ADDRESS_WIDTH-1:0] m_wb_addr;
  logic [BUS_WIDTH*8-1:0]   m_wb_data_o;
  logic [BUS_WIDTH-1:0]     m_wb_sel;
  logic [2:0]               m_wb_cti;
  logic [1:0]               m_wb_bte;
  logic                     m_wb_ack;
  logic [BUS_WIDTH*8-1:0]   m_wb_data_i;

  modport master (
    output m_wb_cyc, m_wb_stb, m_wb_we, m_wb_addr, m_wb_data_o, m_wb_sel, m_wb_cti, m_wb_bte,
    input  m_wb_ack, m_wb_data_i
  );

  modport slave (
    input  m_wb_cyc, m_wb_stb, m_wb_we, m_wb_addr, m_wb_data_o, m_wb_sel, m_wb_cti, m_wb_bte,
    output m_wb_ack, m_wb_data_i
  );
endinterface

// File: rtl/wishbone_classic_burst_master.sv
// Command-driven Wishbone classic master: one incrementing burst per command, write data from a
// valid/ready stream, read data into a 2-entry output buffer.
module wishbone_classic_burst_master #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 4,
  parameter int LEN_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_we,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]     cmd_len,
  input  logic [BUS_WIDTH*8-1:0]   wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [BUS_WIDTH*8-1:0]   rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic                     busy,
  output logic                     done,
  wishbone_classic_burst_master_if.master wb
);
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_STEP = ADDRESS_WIDTH'(BUS_WIDTH);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = ~ADDRESS_WIDTH'(BUS_WIDTH - 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_BEAT = 2'd2} state_t;

  state_t                   state_r, state_next_s;
  logic                     cyc_r, cyc_next_s;
  logic                     stb_r, stb_next_s;
  logic                     we_r, we_next_s;
  logic [ADDRESS_WIDTH-1:0] addr_r, addr_next_s;
  logic [BUS_WIDTH*8-1:0]   data_r, data_next_s;
  logic [BUS_WIDTH-1:0]     sel_r, sel_next_s;
  logic [2:0]               cti_r, cti_next_s;
  logic [LEN_WIDTH-1:0]     len_r, len_next_s;
  logic [LEN_WIDTH-1:0]     cnt_r, cnt_next_s;
  logic                     done_r, done_next_s;
  logic                     cmd_ready_s, wr_ready_s;

  logic [BUS_WIDTH*8-1:0]   buf_r [0:1];
  logic                     head_r;
  logic [1:0]               fill_r;
  logic                     push_s, pop_s;
  logic [1:0]               fill_next_s;
  logic [LEN_WIDTH-1:0]     cnt_inc_s;

  assign pop_s       = (fill_r != 2'd0) & rd_ready;
  assign push_s      = (state_r == ST_BEAT) & wb.m_wb_ack & ~we_r;
  assign fill_next_s = fill_r - {1'b0, pop_s} + {1'b0, push_s};
  assign cnt_inc_s   = cnt_r + LEN_WIDTH'(1);

  // Next-state and next-output logic of the burst sequencer.
  always_comb begin
    state_next_s = state_r;
    cyc_next_s   = cyc_r;
    stb_next_s   = stb_r;
    we_next_s    = we_r;
    addr_next_s  = addr_r;
    data_next_s  = data_r;
    sel_next_s   = sel_r;
    cti_next_s   = cti_r;
    len_next_s   = len_r;
    cnt_next_s   = cnt_r;
    done_next_s  = 1'b0;
    cmd_ready_s  = 1'b0;
    wr_ready_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cmd_ready_s = 1'b1;
        if (cmd_valid) begin
          state_next_s = ST_WAIT;
          cyc_next_s   = 1'b1;
          we_next_s    = cmd_we;
          addr_next_s  = cmd_addr & ADDR_MASK;
          sel_next_s   = {BUS_WIDTH{1'b1}};
          cti_next_s   = (cmd_len == {LEN_WIDTH{1'b0}}) ? CTI_END : CTI_INCR;
          len_next_s   = cmd_len;
          cnt_next_s   = {LEN_WIDTH{1'b0}};
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (we_r) begin
          wr_ready_s = 1'b1;
          if (wr_valid) begin
            data_next_s  = wr_data;
            stb_next_s   = 1'b1;
            state_next_s = ST_BEAT;
          end else begin
            state_next_s = ST_WAIT;
          end
        end else if (fill_next_s < 2'd2) begin
          stb_next_s   = 1'b1;
          state_next_s = ST_BEAT;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_BEAT: begin
        if (wb.m_wb_ack) begin
          addr_next_s = addr_r + ADDR_STEP;
          cnt_next_s  = cnt_inc_s;
          if (cnt_r == len_r) begin
            state_next_s = ST_IDLE;
            cyc_next_s   = 1'b0;
            stb_next_s   = 1'b0;
            we_next_s    = 1'b0;
            sel_next_s   = {BUS_WIDTH{1'b0}};
            cti_next_s   = CTI_CLASSIC;
            done_next_s  = 1'b1;
          end else begin
            cti_next_s = (cnt_inc_s == len_r) ? CTI_END : CTI_INCR;
            if (we_r) begin
              wr_ready_s = 1'b1;
              if (wr_valid) begin
                data_next_s = wr_data;
              end else begin
                stb_next_s   = 1'b0;
                state_next_s = ST_WAIT;
              end
            end else if (fill_next_s < 2'd2) begin
              state_next_s = ST_BEAT;
            end else begin
              // Buffer would be full after this beat: pause until the consumer pops.
              stb_next_s   = 1'b0;
              state_next_s = ST_WAIT;
            end
          end
        end else begin
          state_next_s = ST_BEAT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cyc_next_s   = 1'b0;
        stb_next_s   = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered bus outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cyc_r   <= 1'b0;
      stb_r   <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= {ADDRESS_WIDTH{1'b0}};
      data_r  <= {(BUS_WIDTH*8){1'b0}};
      sel_r   <= {BUS_WIDTH{1'b0}};
      cti_r   <= 3'b000;
      len_r   <= {LEN_WIDTH{1'b0}};
      cnt_r   <= {LEN_WIDTH{1'b0}};
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cyc_r   <= cyc_next_s;
      stb_r   <= stb_next_s;
      we_r    <= we_next_s;
      addr_r  <= addr_next_s;
      data_r  <= data_next_s;
      sel_r   <= sel_next_s;
      cti_r   <= cti_next_s;
      len_r   <= len_next_s;
      cnt_r   <= cnt_next_s;
      done_r  <= done_next_s;
    end
  end

  // Two-entry read buffer; the tail slot is head ^ fill because a push only happens when fill <= 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_r[0] <= {(BUS_WIDTH*8){1'b0}};
      buf_r[1] <= {(BUS_WIDTH*8){1'b0}};
      head_r   <= 1'b0;
      fill_r   <= 2'd0;
    end else begin
      if (push_s) begin
        buf_r[head_r ^ fill_r[0]] <= wb.m_wb_data_i;
      end else begin
        buf_r[head_r ^ fill_r[0]] <= buf_r[head_r ^ fill_r[0]];
      end
      head_r <= pop_s ? ~head_r : head_r;
      fill_r <= fill_next_s;
    end
  end

  assign cmd_ready      = cmd_ready_s;
  assign wr_ready       = wr_ready_s;
  assign rd_data        = buf_r[head_r];
  assign rd_valid       = (fill_r != 2'd0);
  assign busy           = (state_r != ST_IDLE);
  assign done           = done_r;
  assign wb.m_wb_cyc    = cyc_r;
  assign wb.m_wb_stb    = stb_r;
  assign wb.m_wb_we     = we_r;
  assign wb.m_wb_addr   = addr_r;
  assign wb.m_wb_data_o = data_r;
  assign wb.m_wb_sel    = sel_r;
  assign wb.m_wb_cti    = cti_r;
  assign wb.m_wb_bte    = 2'b00;
endmodule

// File: tb/tb_wishbone_classic_burst_master.sv
// Randomised scoreboard bench for wishbone_classic_burst_master against a word-array slave model.
module tb_wishbone_classic_burst_master;
  localparam int AW = 16;
  localparam int BW = 4;
  localparam int LW = 8;

  logic tb_data_clk = 1'b0;
  always #5 tb_data_clk = ~tb_data_clk;

  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid, rd_ready;
  logic        busy, done;
  logic        ack_en;

  wishbone_classic_burst_master_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) wb ();

  wishbone_classic_burst_master #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .LEN_WIDTH(LW)) dut (
    .clk(tb_data_clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done), .wb(wb)
  );

  logic [31:0] slv_mem [0:16383];
  logic [31:0] ref_mem [0:16383];

  assign wb.m_wb_ack    = wb.m_wb_cyc & wb.m_wb_stb & ack_en;
  assign wb.m_wb_data_i = slv_mem[wb.m_wb_addr[15:2]];

  typedef struct packed {
    logic [15:0] addr;
    logic [2:0]  cti;
    logic        we;
    logic [31:0] data;
  } beat_t;

  beat_t       exp_beats[$];
  logic [31:0] exp_rd[$];
  logic [31:0] wr_q[$];

  int total = 0, bad = 0;
  int acks_seen = 0, done_seen = 0, wait_cycles = 0;
  int ack_prob = 100, wr_prob = 100, rd_prob = 100;
  int stall_at = -1, stall_left = 0, wr_total = 0;
  int done_base = 0, wait_base = 0;
  bit wr_taken = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave acknowledge and consumer ready randomisation.
  initial begin
    ack_en = 1'b0;
    rd_ready = 1'b0;
    forever begin
      @(negedge tb_data_clk);
      ack_en   = (int'($urandom_range(99)) < ack_prob);
      rd_ready = (int'($urandom_range(99)) < rd_prob);
    end
  end

  // Write-data source fed from wr_q, with an optional deliberate stall.
  initial begin
    wr_valid = 1'b0;
    wr_data  = 32'h0;
    forever begin
      @(negedge tb_data_clk);
      if (wr_taken && wr_q.size() > 0) begin
        void'(wr_q.pop_front());
        wr_total++;
      end
      if (wr_total == stall_at && stall_left > 0) begin
        wr_valid = 1'b0;
        stall_left--;
      end else begin
        wr_valid = (wr_q.size() > 0) && (int'($urandom_range(99)) < wr_prob);
      end
      wr_data = (wr_q.size() > 0) ? wr_q[0] : 32'h0;
      #1;
      wr_taken = wr_valid && wr_ready && !rst;
    end
  end

  // Monitor: compares bus beats, read data and done against the expected queues.
  initial begin
    bit    exp_done_next;
    beat_t b;
    exp_done_next = 1'b0;
    for (int i = 0; i < 16384; i++) slv_mem[i] = 32'h0;
    forever begin
      @(negedge tb_data_clk);
      #1;
      if (rst) begin
        exp_done_next = 1'b0;
      end else begin
        if (exp_done_next || done) begin
          check("done_pulse", 64'(done), 64'(exp_done_next));
          if (done) begin
            done_seen++;
            check("done_cyc_low", 64'(wb.m_wb_cyc), 64'd0);
            check("done_cmd_ready", 64'(cmd_ready), 64'd1);
          end
        end
        exp_done_next = 1'b0;
        if (wb.m_wb_stb) check("stb_needs_cyc", 64'(wb.m_wb_cyc), 64'd1);
        if (wb.m_wb_cyc) begin
          if (!wb.m_wb_stb) wait_cycles++;
          check("cycle_expected", 64'(exp_beats.size() != 0), 64'd1);
          if (exp_beats.size() != 0) begin
            b = exp_beats[0];
            check("addr", 64'(wb.m_wb_addr), 64'(b.addr));
            check("cti", 64'(wb.m_wb_cti), 64'(b.cti));
            check("we", 64'(wb.m_wb_we), 64'(b.we));
            check("sel", 64'(wb.m_wb_sel), 64'hF);
            check("bte", 64'(wb.m_wb_bte), 64'd0);
            if (wb.m_wb_stb && wb.m_wb_ack) begin
              if (b.we) begin
                check("wdata", 64'(wb.m_wb_data_o), 64'(b.data));
                slv_mem[wb.m_wb_addr[15:2]] = wb.m_wb_data_o;
              end
              acks_seen++;
              exp_done_next = (b.cti == 3'b111);
              void'(exp_beats.pop_front());
            end
          end
        end
        if (rd_valid && rd_ready) begin
          check("rd_expected", 64'(exp_rd.size() != 0), 64'd1);
          if (exp_rd.size() != 0) check("rd_data", 64'(rd_data), 64'(exp_rd.pop_front()));
        end
      end
    end
  end

  // Reference model: expected beats and read data follow from address arithmetic and ref_mem.
  task automatic issue(input bit we, input logic [15:0] addr, input int len,
                       input logic [31:0] dbase, input bit rand_data);
    logic [15:0] a0, a;
    logic [31:0] d;
    beat_t       b;
    bit          accepted;
    a0 = addr & 16'hFFFC;
    for (int i = 0; i <= len; i++) begin
      a = a0 + 16'(4 * i);
      if (we) begin
        d = rand_data ? $urandom : dbase + 32'(i);
        ref_mem[a[15:2]] = d;
        wr_q.push_back(d);
      end else begin
        d = ref_mem[a[15:2]];
        exp_rd.push_back(d);
      end
      b.addr = a;
      b.cti  = (i < len) ? 3'b010 : 3'b111;
      b.we   = we;
      b.data = we ? d : 32'h0;
      exp_beats.push_back(b);
    end
    done_base = done_seen;
    wait_base = wait_cycles;
    @(negedge tb_data_clk);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_len   = 8'(len);
    accepted  = 1'b0;
    for (int c = 0; c < 200 && !accepted; c++) begin
      #1;
      if (cmd_ready) accepted = 1'b1;
      else @(negedge tb_data_clk);
    end
    check("cmd_accept", 64'(accepted), 64'd1);
    @(negedge tb_data_clk);
    cmd_valid = 1'b0;
    #1;
    check("cyc_after_accept", 64'(wb.m_wb_cyc), 64'd1);
    check("stb_after_accept", 64'(wb.m_wb_stb), 64'd0);
    check("busy_after_accept", 64'(busy), 64'd1);
    check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
  endtask

  task automatic finish_cmd(input int exp_wait);
    for (int c = 0; c < 3000 && done_seen < done_base + 1; c++) @(negedge tb_data_clk);
    repeat (2) @(negedge tb_data_clk);
    #2;
    check("done_count", 64'(done_seen), 64'(done_base + 1));
    check("beats_left", 64'(exp_beats.size()), 64'd0);
    for (int c = 0; c < 3000 && exp_rd.size() != 0; c++) @(negedge tb_data_clk);
    #2;
    check("rd_left", 64'(exp_rd.size()), 64'd0);
    if (exp_wait >= 0) check("wait_cycles", 64'(wait_cycles - wait_base), 64'(exp_wait));
  endtask

  initial begin
    int base_acks, base_done;
    #900000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int base_acks, base_done;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 16'h0; cmd_len = 8'h0;
    for (int i = 0; i < 16384; i++) ref_mem[i] = 32'h0;
    repeat (2) @(negedge tb_data_clk);
    #1;
    check("rst_cyc", 64'(wb.m_wb_cyc), 64'd0);
    check("rst_stb", 64'(wb.m_wb_stb), 64'd0);
    check("rst_we", 64'(wb.m_wb_we), 64'd0);
    check("rst_addr", 64'(wb.m_wb_addr), 64'd0);
    check("rst_data_o", 64'(wb.m_wb_data_o), 64'd0);
    check("rst_cti", 64'(wb.m_wb_cti), 64'd0);
    check("rst_sel", 64'(wb.m_wb_sel), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_wr_ready", 64'(wr_ready), 64'd0);
    @(negedge tb_data_clk);
    rst = 1'b0;
    #1;
    check("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

    // 16-beat write then read back at full rate.
    issue(1'b1, 16'h0000, 15, 32'hAAAA0000, 1'b0);
    finish_cmd(1);
    issue(1'b0, 16'h0000, 15, 32'h0, 1'b0);
    finish_cmd(1);

    // Write with the data stream stalled for 3 cycles after 4 words.
    stall_at = wr_total + 4;
    stall_left = 3;
    issue(1'b1, 16'h0100, 15, 32'hCCCC0000, 1'b0);
    finish_cmd(4);
    issue(1'b0, 16'h0100, 15, 32'h0, 1'b0);
    finish_cmd(1);

    // Read with the consumer stalled: exactly two beats fit in the buffer.
    rd_prob = 0;
    base_acks = acks_seen;
    issue(1'b0, 16'h0000, 7, 32'h0, 1'b0);
    repeat (10) @(negedge tb_data_clk);
    #2;
    check("acks_with_rd_low", 64'(acks_seen - base_acks), 64'd2);
    check("stb_low_rd_full", 64'(wb.m_wb_stb), 64'd0);
    check("cyc_high_rd_full", 64'(wb.m_wb_cyc), 64'd1);
    rd_prob = 100;
    finish_cmd(-1);

    // Single beat, and a two-beat burst wrapping the address space.
    issue(1'b1, 16'h0008, 0, 32'hDEAD0008, 1'b0);
    finish_cmd(1);
    issue(1'b0, 16'h000B, 0, 32'h0, 1'b0);
    finish_cmd(1);
    issue(1'b1, 16'hFFFC, 1, 32'h5A5A0000, 1'b0);
    finish_cmd(1);
    issue(1'b0, 16'hFFFC, 1, 32'h0, 1'b0);
    finish_cmd(1);

    // Reset in the middle of a 16-beat write.
    base_acks = acks_seen;
    base_done = done_seen;
    issue(1'b1, 16'hC000, 15, 32'hBBBB0000, 1'b0);
    for (int c = 0; c < 200 && acks_seen < base_acks + 7; c++) begin
      @(negedge tb_data_clk);
      #2;
    end
    check("acks_before_reset", 64'(acks_seen - base_acks), 64'd7);
    @(posedge tb_data_clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_cyc", 64'(wb.m_wb_cyc), 64'd0);
    check("midrst_stb", 64'(wb.m_wb_stb), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_wr_ready", 64'(wr_ready), 64'd0);
    exp_beats.delete();
    exp_rd.delete();
    wr_q.delete();
    stall_left = 0;
    repeat (2) @(negedge tb_data_clk);
    rst = 1'b0;
    #1;
    check("cmd_ready_after_midrst", 64'(cmd_ready), 64'd1);
    repeat (3) @(negedge tb_data_clk);
    check("no_done_after_midrst", 64'(done_seen), 64'(base_done));
    issue(1'b1, 16'h0200, 3, 32'h12340000, 1'b0);
    finish_cmd(1);
    issue(1'b0, 16'h0200, 3, 32'h0, 1'b0);
    finish_cmd(1);

    // Randomised traffic with random handshake pressure.
    for (int n = 0; n < 30; n++) begin
      ack_prob = 40 + int'($urandom_range(60));
      wr_prob  = 40 + int'($urandom_range(60));
      rd_prob  = 30 + int'($urandom_range(70));
      if ($urandom_range(3) == 0) begin
        stall_at   = wr_total + int'($urandom_range(5));
        stall_left = int'($urandom_range(4));
      end
      issue(1'($urandom_range(1)), 16'($urandom_range(16'h3FFF)), int'($urandom_range(20)),
            32'h0, 1'b1);
      finish_cmd(-1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wishbone_classic_burst_master.md
# wishbone_classic_burst_master

Command-driven Wishbone classic master that feeds `wishbone_classic_block_ram` (or any Wishbone classic slave with `cti`/`bte` support) from simple streaming interfaces. A command supplies a start byte address, a beat count and a direction. The block then runs one Wishbone cycle:

- incrementing-burst tags on every beat except the last;
- write data pulled from a valid/ready input;
- read data pushed into a 2-entry output buffer.

It replaces ad-hoc bench/processor sequencing of the block RAM with a reusable bus front end.

## Interface
- `ADDRESS_WIDTH`, 16, byte address width; matches the slave.
- `BUS_WIDTH`, 4, data bus width in bytes; the data width is `BUS_WIDTH*8`.
- `LEN_WIDTH`, 8, width of `cmd_len`.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_we`  in  1  1 = write burst, 0 = read burst.
- `cmd_addr`  in  `ADDRESS_WIDTH`  start byte address; low `log2(BUS_WIDTH)` bits ignored (forced 0).
- `cmd_len`  in  `LEN_WIDTH`  beats minus one.
- `wr_data`  in  `BUS_WIDTH*8`  write beat data.
- `wr_valid`  in  1  write data offered.
- `wr_ready`  out  1  write data accepted when `wr_valid & wr_ready`.
- `rd_data`  out  `BUS_WIDTH*8`  head of read buffer.
- `rd_valid`  out  1  read buffer non-empty.
- `rd_ready`  in  1  pop read buffer.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse after the final ack.
- `m_wb_cyc`, `m_wb_stb`, `m_wb_we`  out  1 each  Wishbone cycle, strobe and write enable.
- `m_wb_addr`  out  `ADDRESS_WIDTH`  Wishbone byte address.
- `m_wb_data_o`  out  `BUS_WIDTH*8`  Wishbone write data.
- `m_wb_sel`  out  `BUS_WIDTH`  byte selects; all ones during a cycle.
- `m_wb_cti`  out  3  cycle type identifier.
- `m_wb_bte`  out  2  burst type; constant 2'b00 (linear).
- `m_wb_ack`  in  1  slave acknowledge.
- `m_wb_data_i`  in  `BUS_WIDTH*8`  Wishbone read data.

## Operation
- **States:** IDLE, WAIT, BEAT.
- **IDLE**
  - On `cmd_valid`, latch we/addr/len and clear the beat counter.
  - Assert `m_wb_cyc`, drive `m_wb_we = cmd_we`, go to WAIT.
- **WAIT** (`cyc` high, `stb` low)
  - Write: `wr_ready = 1`. On `wr_valid`, register the data into `m_wb_data_o`, raise `stb`, go to BEAT.
  - Read: when buffer count ≤ 1 (after this cycle's pop), raise `stb`, go to BEAT.
- **BEAT:** `stb` and all other master outputs are held stable until `m_wb_ack`. On `stb & ack`:
  - Address advances by `BUS_WIDTH`, modulo `2^ADDRESS_WIDTH`; it wraps silently.
  - The beat counter increments.
  - Read: `m_wb_data_i` is pushed into the buffer.
  - **Last beat** (counter == len): drop `cyc`, `stb` and `we`; set `cti` = 000; pulse `done` next cycle; go to IDLE.
  - **Write, not last:** `wr_ready` is asserted combinationally in that same cycle. If `wr_valid`, load the next data, keep `stb`, stay in BEAT. Otherwise drop `stb` and go to WAIT.
  - **Read, not last:** keep `stb` only if buffer count after push/pop ≤ 1. Otherwise drop `stb` and go to WAIT.
- **`m_wb_cti`**
  - 3'b010 on every beat whose index < len.
  - 3'b111 on the final beat, including the len = 0 single-beat case.
  - Updated together with the address.
- **Read buffer:** 2-entry FIFO. Simultaneous push and pop is legal; the count is unchanged. The buffer can never overflow, by the `stb` rule.
- `cmd_ready` is low outside IDLE; commands are never queued.

## Timing
- Reset values (asynchronous, immediate):
  - `m_wb_cyc`, `m_wb_stb`, `m_wb_we` = 0; `m_wb_addr` = 0; `m_wb_data_o` = 0; `m_wb_cti` = 0; `m_wb_sel` = 0.
  - `rd_valid` = 0; `busy` = 0; `done` = 0; `wr_ready` = 0.
  - State = IDLE; `cmd_ready` = 1 once `rst` deasserts.
- Reset mid-burst: the cycle is abandoned, `cyc` drops immediately, buffered read data is discarded, and there is no `done` pulse.
- Latency:
  - Command accept at edge N → `cyc` high after N.
  - Read: `stb` high after N+1.
  - Write: `stb` high one edge after `wr_valid` is seen in WAIT.
- Throughput: a slave acking every cycle with data always available sustains 1 beat/cycle. Read throughput of 1 beat/cycle additionally requires `rd_ready` held high.
- Final ack at edge M → `cyc` = 0 and `done` = 1 after M; `done` = 0 after M+1; `cmd_ready` = 1 after M.
- Read data: an ack at edge M → `rd_valid` = 1 after M.

## Test plan
- **16-beat write:** `cmd_addr` 0x0000, `cmd_len` 15, `wr_data` 0xAAAA0000..0xAAAA000F, slave acks every cycle.
  - Addresses 0x0000..0x003C.
  - `cti` 010 ×15 then 111.
  - `cyc` continuous; `done` once.
  - RAM holds the values.
- **16-beat read** of the same region with `rd_ready` = 1 → `rd_data` 0xAAAA0000..0xAAAA000F in order, no gaps after the first beat, `cti` pattern as above.
- **Write with `wr_valid` low for 3 cycles after beat 4** → `stb` drops, `cyc` stays high, address stays 0x0010 with `cti` 010 until data arrives; totals unchanged.
- **Read, `rd_ready` held low** → exactly 2 acks taken, then `stb` low with `cyc` high. Releasing `rd_ready` resumes; no data lost or duplicated.
- **Single beat:**
  - len 0 at 0x0008 → one beat, `cti` 111.
  - len 1 at 0xFFFC → addresses 0xFFFC then 0x0000.
- **Reset mid-burst:** assert `rst` at beat 7 of a 16-beat write → `cyc`/`stb` 0 immediately, `busy` 0, no `done`; a new command is accepted normally afterwards.
